// File: rtl/rep3_serial_tx.sv
// Transmit end of the repetition-coded serial link: frames a byte (start, data LSB first,
// even parity, stop) and sends every bit as REP identical chips of CHIP_CYCLES clocks each.
module rep3_serial_tx #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned REP         = 3,
  parameter int unsigned CHIP_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              chip_strobe,
  output logic              frame_done
);

  localparam int unsigned CYC_W  = (CHIP_CYCLES > 1) ? $clog2(CHIP_CYCLES) : 1;
  localparam int unsigned CHIP_W = (REP > 1) ? $clog2(REP) : 1;
  localparam int unsigned BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CYC_W-1:0]    cyc_q, cyc_d;
  logic [CHIP_W-1:0]   chip_q, chip_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic                par_q, par_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;

  logic chip_end;
  logic bit_end;
  logic last_stop;
  logic xfer;

  // Terminal counts of the chip-cycle and chip counters mark chip and bit boundaries.
  assign chip_end  = (cyc_q == CYC_W'(CHIP_CYCLES - 1));
  assign bit_end   = chip_end && (chip_q == CHIP_W'(REP - 1));
  assign last_stop = (state_q == S_STOP) && bit_end;

  // Handshake and pulse outputs are gated by ena so a frozen transmitter shows no activity.
  assign in_ready    = ena && ((state_q == S_IDLE) || last_stop);
  assign xfer        = in_valid && in_ready;
  assign chip_strobe = ena && (state_q != S_IDLE) && (cyc_q == '0);
  assign frame_done  = ena && last_stop;

  assign tx   = tx_q;
  assign busy = busy_q;

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      chip_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      chip_q  <= chip_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and next-register logic; everything holds while ena is low.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    chip_d  = chip_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;

    if (ena) begin
      if (state_q != S_IDLE) begin
        cyc_d = chip_end ? '0 : cyc_q + CYC_W'(1);
        if (chip_end) begin
          chip_d = (chip_q == CHIP_W'(REP - 1)) ? '0 : chip_q + CHIP_W'(1);
        end
      end

      case (state_q)
        S_IDLE: begin
          if (xfer) state_d = S_START;
        end
        S_START: begin
          if (bit_end) state_d = S_DATA;
        end
        S_DATA: begin
          if (bit_end) begin
            if (bit_q == BIT_W'(DATA_W - 1)) begin
              bit_d   = '0;
              state_d = S_PARITY;
            end else begin
              bit_d   = bit_q + BIT_W'(1);
              shreg_d = shreg_q >> 1;
            end
          end
        end
        S_PARITY: begin
          if (bit_end) state_d = S_STOP;
        end
        S_STOP: begin
          if (bit_end) state_d = xfer ? S_START : S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase

      // Parity comes from the captured byte, so later changes on in_data are harmless.
      if (xfer) begin
        shreg_d = in_data;
        par_d   = ^in_data;
      end

      case (state_d)
        S_START:  tx_d = 1'b0;
        S_DATA:   tx_d = shreg_d[0];
        S_PARITY: tx_d = par_d;
        default:  tx_d = 1'b1;
      endcase

      busy_d = (state_d != S_IDLE);
    end
  end

endmodule

// File: doc/rep3_serial_tx.md
Name: rep3_serial_tx

Overview:
- Transmit end of the repetition-coded serial link whose receive end is the bitwise majority voter.
- Accepts a parallel byte over a valid/ready handshake and serialises it into a framed bitstream on one output line.
- Each bit is sent as REP identical chips, so the far-end majority voter can correct single-chip errors per bit.
- Sits between the host-side byte source and the board pad driving the link.

Parameters:
DATA_W, 8, payload bits per frame
REP, 3, chips per bit (odd, >=3)
CHIP_CYCLES, 4, clock cycles per chip (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
ena  input  1  enable; low freezes the transmitter
in_data  input  DATA_W  payload byte
in_valid  input  1  in_data is valid
in_ready  output  1  block accepts in_data this cycle
tx  output  1  serial line, idle high
busy  output  1  frame in progress
chip_strobe  output  1  one-cycle pulse on the first cycle of every chip
frame_done  output  1  one-cycle pulse on the final cycle of the stop bit

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: tx=1, busy=0, in_ready=1, chip_strobe=0, frame_done=0, state=IDLE, all counters 0.
- Frame format, each bit held for REP*CHIP_CYCLES clocks (BT):
  - start bit 0;
  - DATA_W data bits, LSB first;
  - even-parity bit = XOR of all data bits;
  - stop bit 1.
- Frame length is (DATA_W+3)*BT clocks (132 at defaults).
- Handshake:
  - Transfer occurs when in_valid & in_ready & ena at a rising edge.
  - in_data is captured into a shift register on that edge.
  - in_data and in_valid are don't-care otherwise.
- in_ready is high in IDLE, and in the final cycle of STOP (frame_done cycle) so frames can run back-to-back. It is low at all other times and whenever ena=0.
- State machine:
  - IDLE -> START on transfer.
  - START -> DATA after BT cycles.
  - DATA -> PARITY after DATA_W*BT cycles.
  - PARITY -> STOP after BT cycles.
  - STOP -> START if a transfer occurs in its last cycle, else IDLE.
- Latency: transfer at cycle 0 -> tx=0 from cycle 1. tx is registered with no combinational path from inputs.
- Counters:
  - chip-cycle counter 0..CHIP_CYCLES-1;
  - chip counter 0..REP-1;
  - bit index 0..DATA_W-1.
  - All wrap to 0 at terminal count and advance only when ena=1.
- busy=1 from cycle 1 through the final STOP cycle inclusive. It stays 1 across back-to-back frames.
- chip_strobe: high when the chip-cycle counter is 0 and state is not IDLE; the first strobe is at cycle 1.
- ena=0 mid-frame:
  - all state, counters and tx hold their value;
  - chip_strobe and frame_done are forced 0;
  - on resumption, timing continues exactly where it paused, with no extra or lost cycles.
- rst mid-frame: the next cycle shows reset values and the partial frame is discarded. rst overrides ena and in_valid.
- Parity is computed from the captured byte, not from live in_data.

Test Plan:
- Reset then idle, in_valid=0 for 20 cycles -> tx=1, busy=0, in_ready=1 throughout.
- Send 0xA5 at cycle 0 -> tx sequence and timing:
  - cycles 1–12: tx=0 (start);
  - data bits 1,0,1,0,0,1,0,1, each 12 cycles, spanning cycles 13–108;
  - cycles 109–120: tx=0 (parity);
  - cycles 121–132: tx=1 (stop).
  - frame_done=1 only at cycle 132, chip_strobe at cycles 1,5,9,...,129.
- Send 0x07 then 0xFF with in_valid held high:
  - second transfer occurs at cycle 132 and its start bit begins at cycle 133;
  - parity bits are 1 then 0;
  - busy never drops between frames.
- Send 0x3C; drop ena for 10 cycles starting at cycle 50:
  - tx frozen at its cycle-49 value;
  - no strobes while ena=0;
  - frame_done occurs at cycle 142.
- Assert rst at cycle 60 of a 0x55 frame:
  - cycle 61: tx=1, busy=0, in_ready=1;
  - a new 0x81 sent at cycle 62 produces a correct full frame starting at cycle 63.
- Loopback: tx into the bitwise majority receiver with one chip of every bit inverted -> receiver recovers bytes 0x00, 0xFF, 0xA5, 0x5A exactly.
